// File: rtl/icb_dma_m.sv
// icb_dma_m: single-channel ICB initiator that copies len 32-bit words
// from src_addr to dst_addr, one bus transaction outstanding at a time.
// Optional build macro DMA_WRSP_EN adds a WR_RSP state so each write also
// waits for a write response before the pointers and count advance.
module icb_dma_m #(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             dma_irq,
    input  logic             irq_clr,
    output logic             m_icb_cmd_valid,
    input  logic             m_icb_cmd_ready,
    output logic [31:0]      m_icb_cmd_addr,
    output logic             m_icb_cmd_read,
    output logic [31:0]      m_icb_cmd_wdata,
    output logic [3:0]       m_icb_cmd_wmask,
    input  logic             m_icb_rsp_valid,
    output logic             m_icb_rsp_ready,
    input  logic             m_icb_rsp_err,
    input  logic [31:0]      m_icb_rsp_rdata
);

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RD_CMD = 3'd1,
        ST_RD_RSP = 3'd2,
        ST_WR_CMD = 3'd3,
        ST_DONE   = 3'd4
`ifdef DMA_WRSP_EN
        ,ST_WR_RSP = 3'd5
`endif
    } state_t;

    state_t           state_r;
    logic [31:0]      src_ptr_r;
    logic [31:0]      dst_ptr_r;
    logic [LEN_W-1:0] remain_r;

    logic             cmd_hs_s;
    logic             rsp_hs_s;
    logic             last_s;
    logic             advance_s;
    logic             enter_done_s;
    logic [31:0]      src_next_s;
    logic [31:0]      dst_next_s;
    logic [LEN_W-1:0] remain_next_s;

    // Handshake decode, next pointer values and the events that end a word or a transfer.
    always_comb begin
        cmd_hs_s      = m_icb_cmd_valid & m_icb_cmd_ready;
        rsp_hs_s      = m_icb_rsp_valid & m_icb_rsp_ready;
        src_next_s    = src_ptr_r + 32'd4;
        dst_next_s    = dst_ptr_r + 32'd4;
        remain_next_s = remain_r - LEN_ONE;
        last_s        = (remain_r == LEN_ONE);
        advance_s     = 1'b0;
        enter_done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                enter_done_s = start & (len == LEN_ZERO);
            end
            ST_RD_RSP: begin
                enter_done_s = rsp_hs_s & m_icb_rsp_err;
            end
`ifdef DMA_WRSP_EN
            ST_WR_RSP: begin
                advance_s    = rsp_hs_s & ~m_icb_rsp_err;
                enter_done_s = rsp_hs_s & (m_icb_rsp_err | last_s);
            end
`else
            ST_WR_CMD: begin
                advance_s    = cmd_hs_s;
                enter_done_s = cmd_hs_s & last_s;
            end
`endif
            default: begin
                advance_s    = 1'b0;
                enter_done_s = 1'b0;
            end
        endcase
    end

    // Transfer FSM; every bus-facing output is a register updated here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= ST_IDLE;
            src_ptr_r       <= 32'd0;
            dst_ptr_r       <= 32'd0;
            remain_r        <= LEN_ZERO;
            busy            <= 1'b0;
            done            <= 1'b0;
            err             <= 1'b0;
            m_icb_cmd_valid <= 1'b0;
            m_icb_cmd_read  <= 1'b0;
            m_icb_cmd_addr  <= 32'd0;
            m_icb_cmd_wdata <= 32'd0;
            m_icb_cmd_wmask <= 4'h0;
            m_icb_rsp_ready <= 1'b0;
        end else begin
            done <= enter_done_s;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        err  <= 1'b0;
                        if (len != LEN_ZERO) begin
                            src_ptr_r       <= src_addr & 32'hFFFF_FFFC;
                            dst_ptr_r       <= dst_addr & 32'hFFFF_FFFC;
                            remain_r        <= len;
                            m_icb_cmd_valid <= 1'b1;
                            m_icb_cmd_read  <= 1'b1;
                            m_icb_cmd_addr  <= src_addr & 32'hFFFF_FFFC;
                            m_icb_cmd_wmask <= 4'h0;
                            state_r         <= ST_RD_CMD;
                        end else begin
                            state_r <= ST_DONE;
                        end
                    end
                end
                ST_RD_CMD: begin
                    if (cmd_hs_s) begin
                        m_icb_cmd_valid <= 1'b0;
                        m_icb_rsp_ready <= 1'b1;
                        state_r         <= ST_RD_RSP;
                    end
                end
                ST_RD_RSP: begin
                    if (rsp_hs_s) begin
                        m_icb_rsp_ready <= 1'b0;
                        if (m_icb_rsp_err) begin
                            err     <= 1'b1;
                            state_r <= ST_DONE;
                        end else begin
                            m_icb_cmd_wdata <= m_icb_rsp_rdata;
                            m_icb_cmd_valid <= 1'b1;
                            m_icb_cmd_read  <= 1'b0;
                            m_icb_cmd_addr  <= dst_ptr_r;
                            m_icb_cmd_wmask <= 4'hF;
                            state_r         <= ST_WR_CMD;
                        end
                    end
                end
                ST_WR_CMD: begin
                    if (cmd_hs_s) begin
                        m_icb_cmd_valid <= 1'b0;
`ifdef DMA_WRSP_EN
                        m_icb_rsp_ready <= 1'b1;
                        state_r         <= ST_WR_RSP;
`endif
                    end
                end
`ifdef DMA_WRSP_EN
                ST_WR_RSP: begin
                    if (rsp_hs_s) begin
                        m_icb_rsp_ready <= 1'b0;
                        if (m_icb_rsp_err) begin
                            err     <= 1'b1;
                            state_r <= ST_DONE;
                        end
                    end
                end
`endif
                ST_DONE: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy            <= 1'b0;
                    m_icb_cmd_valid <= 1'b0;
                    m_icb_rsp_ready <= 1'b0;
                    state_r         <= ST_IDLE;
                end
            endcase
            // Word completion: placed after the case so its next-read command
            // overrides the cmd_valid drop issued by the write handshake above.
            if (advance_s) begin
                src_ptr_r <= src_next_s;
                dst_ptr_r <= dst_next_s;
                remain_r  <= remain_next_s;
                if (last_s) begin
                    state_r <= ST_DONE;
                end else begin
                    m_icb_cmd_valid <= 1'b1;
                    m_icb_cmd_read  <= 1'b1;
                    m_icb_cmd_addr  <= src_next_s;
                    m_icb_cmd_wmask <= 4'h0;
                    state_r         <= ST_RD_CMD;
                end
            end
        end
    end

    // Level interrupt: set on entry to DONE, a same-cycle clear wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            dma_irq <= 1'b0;
        end else if (irq_clr) begin
            dma_irq <= 1'b0;
        end else if (enter_done_s) begin
            dma_irq <= 1'b1;
        end
    end

endmodule

// File: tb/tb_icb_dma_m.sv
// tb_icb_dma_m: directed and randomized copies against a bench-side ICB slave
// and a transaction-list reference model built from the copy rules.
module tb_icb_dma_m;
    localparam int LEN_W = 16;
`ifdef DMA_WRSP_EN
    localparam int CPW = 4;
`else
    localparam int CPW = 3;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic        read;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } txn_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             err;
    logic             dma_irq;
    logic             irq_clr;
    logic             m_icb_cmd_valid;
    logic             m_icb_cmd_ready;
    logic [31:0]      m_icb_cmd_addr;
    logic             m_icb_cmd_read;
    logic [31:0]      m_icb_cmd_wdata;
    logic [3:0]       m_icb_cmd_wmask;
    logic             m_icb_rsp_valid;
    logic             m_icb_rsp_ready;
    logic             m_icb_rsp_err;
    logic [31:0]      m_icb_rsp_rdata;

    always #5 clk = ~clk;

    icb_dma_m #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .busy(busy), .done(done), .err(err), .dma_irq(dma_irq), .irq_clr(irq_clr),
        .m_icb_cmd_valid(m_icb_cmd_valid), .m_icb_cmd_ready(m_icb_cmd_ready),
        .m_icb_cmd_addr(m_icb_cmd_addr), .m_icb_cmd_read(m_icb_cmd_read),
        .m_icb_cmd_wdata(m_icb_cmd_wdata), .m_icb_cmd_wmask(m_icb_cmd_wmask),
        .m_icb_rsp_valid(m_icb_rsp_valid), .m_icb_rsp_ready(m_icb_rsp_ready),
        .m_icb_rsp_err(m_icb_rsp_err), .m_icb_rsp_rdata(m_icb_rsp_rdata)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc, done_cnt, done_cyc, cmdv_cnt, rd_cnt;
    int          stall_idx, stall_len, stall_used, err_idx;
    bit          rsp_pend, hold_rsp, rsp_err_q;
    logic [31:0] rsp_data_q, cap_addr;
    txn_t        log_q[$];
    logic [31:0] mem [logic [31:0]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], 16'hA5C3};
    endfunction

    // Slave behaviour for the current cycle; handshakes logged here complete at the next edge.
    task automatic drive_slave();
        txn_t t;
        logic rdy;
        if (rsp_pend && !hold_rsp) begin
            m_icb_rsp_valid = 1'b1;
            m_icb_rsp_rdata = rsp_data_q;
            m_icb_rsp_err   = rsp_err_q;
            if (m_icb_rsp_ready === 1'b1) rsp_pend = 1'b0;
        end else begin
            m_icb_rsp_valid = 1'b0;
            m_icb_rsp_rdata = 32'd0;
            m_icb_rsp_err   = 1'b0;
        end
        rdy = 1'b1;
        if (stall_len > 0 && rd_cnt == stall_idx && stall_used > 0) begin
            check("stall_valid", 64'(m_icb_cmd_valid), 64'd1);
            check("stall_read", 64'(m_icb_cmd_read), 64'd1);
            check("stall_addr", 64'(m_icb_cmd_addr), 64'(cap_addr));
        end
        if (m_icb_cmd_valid === 1'b1 && m_icb_cmd_read === 1'b1 && rd_cnt == stall_idx
            && stall_used < stall_len) begin
            if (stall_used == 0) cap_addr = m_icb_cmd_addr;
            stall_used++;
            rdy = 1'b0;
        end
        m_icb_cmd_ready = rdy;
        if (m_icb_cmd_valid === 1'b1 && rdy) begin
            t.addr  = m_icb_cmd_addr;
            t.read  = m_icb_cmd_read;
            t.wdata = m_icb_cmd_wdata;
            t.wmask = m_icb_cmd_wmask;
            log_q.push_back(t);
            if (m_icb_cmd_read === 1'b1) begin
                rsp_pend   = 1'b1;
                rsp_data_q = rd_word(m_icb_cmd_addr);
                rsp_err_q  = (rd_cnt == err_idx);
                rd_cnt++;
            end else begin
`ifdef DMA_WRSP_EN
                rsp_pend   = 1'b1;
                rsp_data_q = 32'd0;
                rsp_err_q  = 1'b0;
`endif
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (m_icb_cmd_valid === 1'b1) cmdv_cnt++;
        drive_slave();
    endtask

    task automatic run_xfer(input string name, input logic [31:0] s, input logic [31:0] d,
                            input int n, input int st_idx, input int st_len, input int e_idx,
                            input bit clr_last, input int poke_at);
        txn_t        exp_q[$];
        txn_t        t;
        logic [31:0] sa, da, a;
        int          n_rd, exp_done;
        bit          aborted;
        logic        busy1, cmdv1, busy_end;
        sa = s & 32'hFFFF_FFFC;
        da = d & 32'hFFFF_FFFC;
        aborted = (e_idx >= 0) && (e_idx < n);
        for (int i = 0; i < n; i++) begin
            a = sa + 32'(4 * i);
            mem[a] = $urandom();
            t.addr = a; t.read = 1'b1; t.wdata = 32'd0; t.wmask = 4'h0;
            exp_q.push_back(t);
            if (aborted && i == e_idx) break;
            t.addr = da + 32'(4 * i); t.read = 1'b0; t.wdata = mem[a]; t.wmask = 4'hF;
            exp_q.push_back(t);
        end
        n_rd = aborted ? e_idx + 1 : n;
        if (n == 0) exp_done = 1;
        else if (aborted) exp_done = CPW * e_idx + 3;
        else exp_done = CPW * n + 1;
        if (st_len > 0 && st_idx < n_rd) exp_done += st_len;

        log_q.delete();
        cyc = 0; done_cnt = 0; done_cyc = -1; cmdv_cnt = 0; rd_cnt = 0;
        stall_idx = st_idx; stall_len = st_len; stall_used = 0; err_idx = e_idx;
        busy1 = 1'b0; cmdv1 = 1'b0;
        start = 1'b1; src_addr = s; dst_addr = d; len = LEN_W'(n); irq_clr = 1'b0;
        while (cyc < exp_done + 3) begin
            tick();
            start = 1'b0;
            if (cyc == poke_at) begin
                start = 1'b1;
                src_addr = $urandom();
                dst_addr = $urandom();
                len = LEN_W'($urandom_range(1, 50));
            end
            irq_clr = clr_last && (cyc == exp_done - 1);
            if (cyc == 1) begin
                busy1 = busy;
                cmdv1 = m_icb_cmd_valid;
            end
        end
        busy_end = busy;
        irq_clr = 1'b0;

        check({name, "_ntxn"}, 64'(log_q.size()), 64'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && j < log_q.size(); j++) begin
            check($sformatf("%s_addr%0d", name, j), 64'(log_q[j].addr), 64'(exp_q[j].addr));
            check($sformatf("%s_rd%0d", name, j), 64'(log_q[j].read), 64'(exp_q[j].read));
            check($sformatf("%s_mask%0d", name, j), 64'(log_q[j].wmask), 64'(exp_q[j].wmask));
            if (!exp_q[j].read)
                check($sformatf("%s_data%0d", name, j), 64'(log_q[j].wdata), 64'(exp_q[j].wdata));
        end
        check({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check({name, "_done_cyc"}, 64'(done_cyc), 64'(exp_done));
        check({name, "_err"}, 64'(err), 64'(aborted));
        check({name, "_irq"}, 64'(dma_irq), 64'(!clr_last));
        check({name, "_busy1"}, 64'(busy1), 64'd1);
        check({name, "_cmdv1"}, 64'(cmdv1), 64'(n > 0));
        check({name, "_busy_end"}, 64'(busy_end), 64'd0);
        if (n == 0) check({name, "_no_cmd"}, 64'(cmdv_cnt), 64'd0);
    endtask

    initial begin
        int n, si, sl, ei;
        rst = 1'b1; start = 1'b0; src_addr = 32'd0; dst_addr = 32'd0; len = '0; irq_clr = 1'b0;
        m_icb_cmd_ready = 1'b1; m_icb_rsp_valid = 1'b0; m_icb_rsp_err = 1'b0; m_icb_rsp_rdata = 32'd0;
        rsp_pend = 1'b0; hold_rsp = 1'b0; rsp_err_q = 1'b0; rsp_data_q = 32'd0; cap_addr = 32'd0;
        cyc = 0; done_cnt = 0; done_cyc = -1; cmdv_cnt = 0; rd_cnt = 0;
        stall_idx = 0; stall_len = 0; stall_used = 0; err_idx = -1;

        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_irq", 64'(dma_irq), 64'd0);
        check("rst_cmd_valid", 64'(m_icb_cmd_valid), 64'd0);
        check("rst_cmd_read", 64'(m_icb_cmd_read), 64'd0);
        check("rst_cmd_addr", 64'(m_icb_cmd_addr), 64'd0);
        check("rst_cmd_wdata", 64'(m_icb_cmd_wdata), 64'd0);
        check("rst_cmd_wmask", 64'(m_icb_cmd_wmask), 64'd0);
        check("rst_rsp_ready", 64'(m_icb_rsp_ready), 64'd0);
        rst = 1'b0;
        tick();

        run_xfer("copy4", 32'h0000_1000, 32'h0000_2000, 4, 0, 0, -1, 1'b0, -1);
        run_xfer("stall", 32'h0000_1100, 32'h0000_2100, 4, 1, 5, -1, 1'b0, -1);
        run_xfer("rderr", 32'h0000_1200, 32'h0000_2200, 8, 0, 0, 2, 1'b0, -1);
        run_xfer("errclr_poke", 32'h0000_1303, 32'h0000_2302, 2, 0, 0, -1, 1'b0, 2);
        run_xfer("len0", 32'h0000_1400, 32'h0000_2400, 0, 0, 0, -1, 1'b0, -1);
        run_xfer("wrap", 32'hFFFF_FFF8, 32'hFFFF_FFFC, 3, 0, 0, -1, 1'b0, -1);

        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("irq_clr", 64'(dma_irq), 64'd0);
        run_xfer("clr_vs_set", 32'h0000_1500, 32'h0000_2500, 3, 0, 0, -1, 1'b1, -1);

        for (int r = 0; r < 8; r++) begin
            n  = int'($urandom_range(1, 6));
            si = int'($urandom_range(0, n - 1));
            sl = int'($urandom_range(0, 3));
            ei = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
            run_xfer($sformatf("rnd%0d", r), $urandom(), $urandom(), n, si, sl, ei, 1'b0, -1);
        end

        // Reset while a read response is outstanding.
        log_q.delete(); rd_cnt = 0; stall_len = 0; stall_used = 0; err_idx = -1; hold_rsp = 1'b1;
        start = 1'b1; src_addr = 32'h0000_3000; dst_addr = 32'h0000_4000; len = LEN_W'(4);
        tick();
        start = 1'b0;
        tick();
        check("mid_in_rd_rsp", 64'(m_icb_rsp_ready), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_cmd_valid", 64'(m_icb_cmd_valid), 64'd0);
        check("mid_rsp_ready", 64'(m_icb_rsp_ready), 64'd0);
        check("mid_irq", 64'(dma_irq), 64'd0);
        hold_rsp = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("late_rsp_ready", 64'(m_icb_rsp_ready), 64'd0);
            check("late_busy", 64'(busy), 64'd0);
            check("late_cmd_valid", 64'(m_icb_cmd_valid), 64'd0);
        end
        check("late_ntxn", 64'(log_q.size()), 64'd1);
        rsp_pend = 1'b0;
        m_icb_rsp_valid = 1'b0;
        m_icb_rsp_err = 1'b0;
        run_xfer("after_rst", 32'h0000_5000, 32'h0000_6000, 2, 0, 0, -1, 1'b0, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
